// File: rtl/stream_deskew.sv
// Aligns a late stream to an early one by buffering early samples in a
// small circular FIFO and pairing them in order with late samples.
module stream_deskew #(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_SKEW   = 16
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [$clog2(MAX_SKEW+1)-1:0] CFG_SKEW,
   input  logic                          CFG_LOAD,
   input  logic                          LEAD_VLD,
   input  logic [DATA_WIDTH-1:0]         LEAD_DAT,
   input  logic                          LAG_VLD,
   input  logic [DATA_WIDTH-1:0]         LAG_DAT,
   output logic                          OUT_VLD,
   output logic [DATA_WIDTH-1:0]         OUT_LEAD,
   output logic [DATA_WIDTH-1:0]         OUT_LAG,
   output logic                          LOCKED,
   output logic [2:0]                    ERR
);

   localparam int AW = $clog2(MAX_SKEW);
   localparam int SW = $clog2(MAX_SKEW + 1);
   localparam logic [SW-1:0] FULL = SW'(MAX_SKEW);

   typedef enum logic [1:0] {IDLE, ALIGN, LOCK} state_t;

   state_t                state_q, state_d;
   logic [AW-1:0]         wr_q, wr_d;
   logic [AW-1:0]         rd_q, rd_d;
   logic [SW-1:0]         cnt_q, cnt_d;
   logic [SW-1:0]         skew_q, skew_d;
   logic [2:0]            err_q, err_d;
   logic                  vld_q, vld_d;
   logic [DATA_WIDTH-1:0] lead_q, lead_d;
   logic [DATA_WIDTH-1:0] lag_q, lag_d;
   logic                  locked_q, locked_d;
   logic                  we;
   logic                  empty, full;

   logic [DATA_WIDTH-1:0] mem_q [MAX_SKEW];

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == FULL);

   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      skew_d  = skew_q;
      err_d   = err_q;
      vld_d   = 1'b0;
      lead_d  = lead_q;
      lag_d   = lag_q;
      we      = 1'b0;
      if (CFG_LOAD) begin
         skew_d  = (CFG_SKEW > FULL) ? FULL : CFG_SKEW;
         wr_d    = '0;
         rd_d    = '0;
         cnt_d   = '0;
         err_d   = '0;
         state_d = IDLE;
      end else begin
         if (LAG_VLD) begin
            if (empty && LEAD_VLD) begin
               vld_d  = 1'b1;
               lead_d = LEAD_DAT;
               lag_d  = LAG_DAT;
            end else if (empty) begin
               err_d[1] = 1'b1;
            end else begin
               vld_d  = 1'b1;
               lead_d = mem_q[rd_q];
               lag_d  = LAG_DAT;
               rd_d   = rd_q + AW'(1);
               if (LEAD_VLD) begin
                  we   = 1'b1;
                  wr_d = wr_q + AW'(1);
               end else begin
                  cnt_d = cnt_q - SW'(1);
               end
            end
         end else if (LEAD_VLD) begin
            if (full) begin
               err_d[0] = 1'b1;
            end else begin
               we    = 1'b1;
               wr_d  = wr_q + AW'(1);
               cnt_d = cnt_q + SW'(1);
            end
         end
         unique case (state_q)
            IDLE:
               if (LEAD_VLD || LAG_VLD) state_d = ALIGN;
            ALIGN:
               if (LAG_VLD) begin
                  state_d = LOCK;
                  // occupancy before the pop is the observed skew
                  if (cnt_q != skew_q) err_d[2] = 1'b1;
               end
            LOCK:
               state_d = LOCK;
            default:
               state_d = IDLE;
         endcase
      end
      locked_d = (state_d == LOCK) && !err_d[2];
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= IDLE;
         wr_q     <= '0;
         rd_q     <= '0;
         cnt_q    <= '0;
         skew_q   <= '0;
         err_q    <= '0;
         vld_q    <= 1'b0;
         lead_q   <= '0;
         lag_q    <= '0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         cnt_q    <= cnt_d;
         skew_q   <= skew_d;
         err_q    <= err_d;
         vld_q    <= vld_d;
         lead_q   <= lead_d;
         lag_q    <= lag_d;
         locked_q <= locked_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (we && !RST) mem_q[wr_q] <= LEAD_DAT;
   end

   assign OUT_VLD  = vld_q;
   assign OUT_LEAD = lead_q;
   assign OUT_LAG  = lag_q;
   assign LOCKED   = locked_q;
   assign ERR      = err_q;

endmodule

// File: tb/tb_stream_deskew.sv
// Directed self-checking bench for stream_deskew (DATA_WIDTH=8, MAX_SKEW=16).
module tb_stream_deskew;

   logic       CLK = 1'b0;
   logic       RST;
   logic [4:0] CFG_SKEW;
   logic       CFG_LOAD;
   logic       LEAD_VLD;
   logic [7:0] LEAD_DAT;
   logic       LAG_VLD;
   logic [7:0] LAG_DAT;
   logic       OUT_VLD;
   logic [7:0] OUT_LEAD;
   logic [7:0] OUT_LAG;
   logic       LOCKED;
   logic [2:0] ERR;

   int errors = 0;
   int checks = 0;

   stream_deskew #(.DATA_WIDTH(8), .MAX_SKEW(16)) dut (
      .CLK(CLK), .RST(RST),
      .CFG_SKEW(CFG_SKEW), .CFG_LOAD(CFG_LOAD),
      .LEAD_VLD(LEAD_VLD), .LEAD_DAT(LEAD_DAT),
      .LAG_VLD(LAG_VLD), .LAG_DAT(LAG_DAT),
      .OUT_VLD(OUT_VLD), .OUT_LEAD(OUT_LEAD), .OUT_LAG(OUT_LAG),
      .LOCKED(LOCKED), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic lv, input logic [7:0] ld,
                        input logic gv, input logic [7:0] gd);
      LEAD_VLD = lv;
      LEAD_DAT = ld;
      LAG_VLD  = gv;
      LAG_DAT  = gd;
   endtask

   // load with both valids high: they must be ignored
   task automatic cfg(input logic [4:0] s);
      CFG_SKEW = s;
      CFG_LOAD = 1'b1;
      drive(1'b1, 8'hEE, 1'b1, 8'hEE);
      step();
      CFG_LOAD = 1'b0;
      drive(1'b0, 8'h00, 1'b0, 8'h00);
   endtask

   task automatic test_reset();
      RST = 1'b1;
      CFG_SKEW = 5'd3;
      CFG_LOAD = 1'b1;
      drive(1'b1, 8'h55, 1'b1, 8'hAA);
      step();
      checks++;
      if (OUT_VLD !== 1'b0) begin
         errors++; $display("FAIL reset_vld got=%b exp=0", OUT_VLD);
      end
      checks++;
      if (OUT_LEAD !== 8'h00 || OUT_LAG !== 8'h00) begin
         errors++; $display("FAIL reset_data got=%h/%h exp=00/00", OUT_LEAD, OUT_LAG);
      end
      checks++;
      if (LOCKED !== 1'b0 || ERR !== 3'b000) begin
         errors++; $display("FAIL reset_status got=%b/%b exp=0/000", LOCKED, ERR);
      end
      RST = 1'b0;
      CFG_LOAD = 1'b0;
      drive(1'b0, 8'h00, 1'b0, 8'h00);
      step();
      checks++;
      if (OUT_VLD !== 1'b0 || ERR !== 3'b000) begin
         errors++; $display("FAIL reset_idle got=%b/%b exp=0/000", OUT_VLD, ERR);
      end
   endtask

   task automatic test_skew3();
      cfg(5'd3);
      for (int c = 0; c < 11; c++) begin
         drive(c < 8, 8'(16 + c), c >= 3, 8'(160 + c - 3));
         step();
         checks++;
         if (c >= 3) begin
            if (OUT_VLD !== 1'b1 || OUT_LEAD !== 8'(16 + c - 3) ||
                OUT_LAG !== 8'(160 + c - 3)) begin
               errors++;
               $display("FAIL skew3_pair c=%0d got=%b %h %h exp=1 %h %h", c,
                        OUT_VLD, OUT_LEAD, OUT_LAG, 8'(16 + c - 3), 8'(160 + c - 3));
            end
         end else if (OUT_VLD !== 1'b0) begin
            errors++; $display("FAIL skew3_novld c=%0d got=%b exp=0", c, OUT_VLD);
         end
      end
      drive(1'b0, 8'h00, 1'b0, 8'h00);
      step();
      checks++;
      if (OUT_VLD !== 1'b0 || OUT_LEAD !== 8'h17 || OUT_LAG !== 8'hA7) begin
         errors++;
         $display("FAIL skew3_hold got=%b %h %h exp=0 17 a7", OUT_VLD, OUT_LEAD, OUT_LAG);
      end
      checks++;
      if (LOCKED !== 1'b1 || ERR !== 3'b000) begin
         errors++; $display("FAIL skew3_status got=%b/%b exp=1/000", LOCKED, ERR);
      end
   endtask

   task automatic test_bypass();
      cfg(5'd0);
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 8'(48 + i), 1'b1, 8'(192 + i));
         step();
         checks++;
         if (OUT_VLD !== 1'b1 || OUT_LEAD !== 8'(48 + i) || OUT_LAG !== 8'(192 + i)) begin
            errors++;
            $display("FAIL bypass_pair i=%0d got=%b %h %h exp=1 %h %h", i,
                     OUT_VLD, OUT_LEAD, OUT_LAG, 8'(48 + i), 8'(192 + i));
         end
      end
      drive(1'b0, 8'h00, 1'b0, 8'h00);
      step();
      checks++;
      if (LOCKED !== 1'b1 || ERR !== 3'b000) begin
         errors++; $display("FAIL bypass_status got=%b/%b exp=1/000", LOCKED, ERR);
      end
      // buffer must still be empty: a lone lag underflows
      drive(1'b0, 8'h00, 1'b1, 8'hCC);
      step();
      checks++;
      if (OUT_VLD !== 1'b0 || ERR !== 3'b010) begin
         errors++; $display("FAIL bypass_empty got=%b/%b exp=0/010", OUT_VLD, ERR);
      end
      drive(1'b0, 8'h00, 1'b0, 8'h00);
   endtask

   task automatic test_underflow();
      cfg(5'd0);
      checks++;
      if (OUT_VLD !== 1'b0 || ERR !== 3'b000 || LOCKED !== 1'b0) begin
         errors++;
         $display("FAIL load_clear got=%b/%b/%b exp=0/000/0", OUT_VLD, ERR, LOCKED);
      end
      drive(1'b0, 8'h00, 1'b1, 8'h99);
      step();
      checks++;
      if (OUT_VLD !== 1'b0 || ERR !== 3'b010) begin
         errors++; $display("FAIL underflow got=%b/%b exp=0/010", OUT_VLD, ERR);
      end
      drive(1'b0, 8'h00, 1'b0, 8'h00);
      step();
      checks++;
      if (ERR !== 3'b010) begin
         errors++; $display("FAIL underflow_sticky got=%b exp=010", ERR);
      end
   endtask

   task automatic test_overflow();
      cfg(5'd31);
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, 8'(64 + i), 1'b0, 8'h00);
         step();
         if (i == 15) begin
            checks++;
            if (ERR !== 3'b000) begin
               errors++; $display("FAIL ovf_at_full got=%b exp=000", ERR);
            end
         end
      end
      checks++;
      if (ERR !== 3'b001 || OUT_VLD !== 1'b0) begin
         errors++; $display("FAIL ovf_flag got=%b/%b exp=001/0", ERR, OUT_VLD);
      end
      drive(1'b0, 8'h00, 1'b1, 8'hE0);
      step();
      checks++;
      if (OUT_VLD !== 1'b1 || OUT_LEAD !== 8'h40 || OUT_LAG !== 8'hE0) begin
         errors++;
         $display("FAIL ovf_first got=%b %h %h exp=1 40 e0", OUT_VLD, OUT_LEAD, OUT_LAG);
      end
      checks++;
      if (ERR !== 3'b001 || LOCKED !== 1'b1) begin
         errors++; $display("FAIL ovf_clamp got=%b/%b exp=001/1", ERR, LOCKED);
      end
      drive(1'b0, 8'h00, 1'b0, 8'h00);
   endtask

   task automatic test_full_push_pop();
      cfg(5'd16);
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 8'(64 + i), 1'b0, 8'h00);
         step();
      end
      drive(1'b1, 8'h50, 1'b1, 8'hE0);
      step();
      checks++;
      if (OUT_VLD !== 1'b1 || OUT_LEAD !== 8'h40 || ERR !== 3'b000) begin
         errors++;
         $display("FAIL full_pp got=%b %h %b exp=1 40 000", OUT_VLD, OUT_LEAD, ERR);
      end
      for (int j = 0; j < 16; j++) begin
         drive(1'b0, 8'h00, 1'b1, 8'(225 + j));
         step();
         checks++;
         if (OUT_VLD !== 1'b1 || OUT_LEAD !== 8'(65 + j) || OUT_LAG !== 8'(225 + j)) begin
            errors++;
            $display("FAIL full_drain j=%0d got=%b %h %h exp=1 %h %h", j,
                     OUT_VLD, OUT_LEAD, OUT_LAG, 8'(65 + j), 8'(225 + j));
         end
      end
      drive(1'b0, 8'h00, 1'b1, 8'hFF);
      step();
      checks++;
      if (OUT_VLD !== 1'b0 || ERR !== 3'b010) begin
         errors++; $display("FAIL full_empty got=%b/%b exp=0/010", OUT_VLD, ERR);
      end
      drive(1'b0, 8'h00, 1'b0, 8'h00);
   endtask

   task automatic test_mismatch();
      cfg(5'd2);
      for (int c = 0; c < 10; c++) begin
         drive(c < 6, 8'(112 + c), c >= 4, 8'(176 + c - 4));
         step();
         if (c >= 4) begin
            checks++;
            if (OUT_VLD !== 1'b1 || OUT_LEAD !== 8'(112 + c - 4) ||
                OUT_LAG !== 8'(176 + c - 4)) begin
               errors++;
               $display("FAIL mis_pair c=%0d got=%b %h %h exp=1 %h %h", c,
                        OUT_VLD, OUT_LEAD, OUT_LAG, 8'(112 + c - 4), 8'(176 + c - 4));
            end
         end
         if (c == 4) begin
            checks++;
            if (ERR !== 3'b100) begin
               errors++; $display("FAIL mis_flag got=%b exp=100", ERR);
            end
         end
      end
      drive(1'b0, 8'h00, 1'b0, 8'h00);
      step();
      checks++;
      if (LOCKED !== 1'b0 || ERR !== 3'b100) begin
         errors++; $display("FAIL mis_status got=%b/%b exp=0/100", LOCKED, ERR);
      end
   endtask

   task automatic test_flush();
      cfg(5'd5);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 8'(128 + i), 1'b0, 8'h00);
         step();
      end
      cfg(5'd1);
      checks++;
      if (OUT_VLD !== 1'b0 || ERR !== 3'b000) begin
         errors++; $display("FAIL flush_load got=%b/%b exp=0/000", OUT_VLD, ERR);
      end
      for (int c = 0; c < 5; c++) begin
         drive(c < 4, 8'(144 + c), c >= 1, 8'(208 + c - 1));
         step();
         if (c >= 1) begin
            checks++;
            if (OUT_VLD !== 1'b1 || OUT_LEAD !== 8'(144 + c - 1) ||
                OUT_LAG !== 8'(208 + c - 1)) begin
               errors++;
               $display("FAIL flush_pair c=%0d got=%b %h %h exp=1 %h %h", c,
                        OUT_VLD, OUT_LEAD, OUT_LAG, 8'(144 + c - 1), 8'(208 + c - 1));
            end
         end
      end
      drive(1'b0, 8'h00, 1'b0, 8'h00);
      step();
      checks++;
      if (LOCKED !== 1'b1 || ERR !== 3'b000) begin
         errors++; $display("FAIL flush_status got=%b/%b exp=1/000", LOCKED, ERR);
      end
   endtask

   task automatic test_mid_reset();
      cfg(5'd3);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 8'(96 + i), 1'b0, 8'h00);
         step();
      end
      RST = 1'b1;
      drive(1'b1, 8'h77, 1'b1, 8'h77);
      step();
      RST = 1'b0;
      drive(1'b0, 8'h00, 1'b0, 8'h00);
      checks++;
      if (OUT_VLD !== 1'b0 || ERR !== 3'b000 || LOCKED !== 1'b0 ||
          OUT_LEAD !== 8'h00) begin
         errors++;
         $display("FAIL midrst_state got=%b/%b/%b/%h exp=0/000/0/00",
                  OUT_VLD, ERR, LOCKED, OUT_LEAD);
      end
      drive(1'b0, 8'h00, 1'b1, 8'hAB);
      step();
      checks++;
      if (OUT_VLD !== 1'b0 || ERR !== 3'b010) begin
         errors++; $display("FAIL midrst_discard got=%b/%b exp=0/010", OUT_VLD, ERR);
      end
      drive(1'b0, 8'h00, 1'b0, 8'h00);
   endtask

   initial begin
      CFG_LOAD = 1'b0;
      CFG_SKEW = '0;
      drive(1'b0, 8'h00, 1'b0, 8'h00);
      RST = 1'b1;
      test_reset();
      test_skew3();
      test_bypass();
      test_underflow();
      test_overflow();
      test_full_push_pop();
      test_mismatch();
      test_flush();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/stream_deskew.md
STREAM_DESKEW -- requirements
Module: stream_deskew

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bit width of each stream sample.
REQ-002 SHALL have parameter MAX_SKEW, default 16, buffer depth in samples (power of two, >=2).
REQ-003 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port CFG_SKEW  input  ceil(log2(MAX_SKEW+1))  expected lead-to-lag sample skew.
REQ-006 SHALL have port CFG_LOAD  input  1  one-cycle pulse; flushes the buffer and latches CFG_SKEW.
REQ-007 SHALL have port LEAD_VLD  input  1  early-stream sample valid.
REQ-008 SHALL have port LEAD_DAT  input  DATA_WIDTH  early-stream sample.
REQ-009 SHALL have port LAG_VLD  input  1  late-stream sample valid.
REQ-010 SHALL have port LAG_DAT  input  DATA_WIDTH  late-stream sample.
REQ-011 SHALL have port OUT_VLD  output  1  aligned pair valid.
REQ-012 SHALL have port OUT_LEAD  output  DATA_WIDTH  buffered lead sample of the pair.
REQ-013 SHALL have port OUT_LAG  output  DATA_WIDTH  lag sample of the pair.
REQ-014 SHALL have port LOCKED  output  1  first pair emitted with correct skew.
REQ-015 SHALL have port ERR  output  3  sticky flags {skew_mismatch, underflow, overflow}.

Function
REQ-016 SHALL buffer lead samples in a MAX_SKEW-entry circular FIFO (write pointer, read pointer, occupancy count 0..MAX_SKEW); pointers wrap from MAX_SKEW-1 to 0.
REQ-017 SHALL pair each LAG_VLD sample with the oldest buffered lead sample, in order, matching by sample count rather than cycle count.
REQ-018 SHALL register outputs: OUT_VLD/OUT_LEAD/OUT_LAG appear exactly 1 cycle after the LAG_VLD cycle; OUT_VLD is 0 on all other cycles, and OUT_LEAD/OUT_LAG hold their last values.
REQ-019 SHALL, with LEAD_VLD and LAG_VLD both high and occupancy 0, bypass: pair LEAD_DAT with LAG_DAT directly; occupancy stays 0.
REQ-020 SHALL, with push and pop in the same cycle at occupancy MAX_SKEW, perform both; occupancy is unchanged and no overflow is flagged.
REQ-021 SHALL, on a push at occupancy MAX_SKEW without a pop, drop the lead sample, set ERR[0], and leave FIFO contents unchanged.
REQ-022 SHALL, on LAG_VLD at occupancy 0 without LEAD_VLD, set ERR[1] and emit no pair.
REQ-023 SHALL run state machine IDLE -> ALIGN -> LOCK.
REQ-024 IDLE SHALL move to ALIGN on the first LEAD_VLD or LAG_VLD after reset/CFG_LOAD.
REQ-025 ALIGN SHALL move to LOCK on the first LAG_VLD; if occupancy at that moment (before pop) != latched skew, SHALL set ERR[2] but still enter LOCK.
REQ-026 LOCK SHALL persist until RST or CFG_LOAD; LOCKED = (state==LOCK) && !ERR[2], registered.
REQ-027 SHALL, on CFG_LOAD, within 1 cycle: latch CFG_SKEW; clear pointers, occupancy and ERR; enter IDLE; ignore same-cycle LEAD_VLD/LAG_VLD; force OUT_VLD 0 next cycle.
REQ-028 SHALL clamp a latched skew greater than MAX_SKEW to MAX_SKEW.
REQ-029 SHALL keep ERR bits sticky until RST or CFG_LOAD.

Reset
REQ-030 SHALL, on RST high at a rising edge: set OUT_VLD=0, OUT_LEAD=0, OUT_LAG=0, LOCKED=0, ERR=0, state IDLE, pointers/occupancy 0, latched skew 0; RST overrides CFG_LOAD and data inputs in that cycle.
REQ-031 SHALL honour RST asserted mid-operation identically; buffered samples are discarded and never output.
REQ-032 SHALL NOT require FIFO storage to be reset.

Verification
REQ-033 Skew 3: lead 0x10..0x17 each cycle, lag 0xA0..0xA7 starting 3 cycles later -> 8 pairs (0x10,0xA0)..(0x17,0xA7), each 1 cycle after its lag; LOCKED=1; ERR=0.
REQ-034 Skew 0, both streams valid in the same cycles -> bypass pairs; occupancy stays 0; LOCKED=1.
REQ-035 MAX_SKEW=16, 17 lead pushes without lag -> ERR=3'b001; first lag pairs with lead #1 (the 17th is dropped).
REQ-036 CFG_SKEW=2, actual skew 4 -> ERR[2]=1, LOCKED=0, pairs still in order.
REQ-037 LAG_VLD with empty buffer -> ERR[1]=1, OUT_VLD stays 0.
REQ-038 CFG_LOAD while occupancy=5, then a clean skew-1 stream -> old samples never appear; ERR=0; LOCKED=1.
